// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path:
// states, opcodes, functs, ALU/extender/mux select codes.
package mips_multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_REX,
    S_ALUWB,
    S_IEX,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    C_NONE,
    C_ADD,
    C_SUB,
    C_R,
    C_I
  } alu_cls_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0a;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] EXT_SIGN  = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_OUT = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  function automatic logic funct_ok(
    input logic [5:0] f
  );
    return (f == FN_ADD) || (f == FN_SUB) ||
           (f == FN_AND) || (f == FN_OR) ||
           (f == FN_SLT);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_dec.sv
// ALU operation and immediate-extender mode decode
// from the current step class and the IR fields.
module mips_multicycle_ctrl_alu_dec
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int ALU_W = 4
) (
  input  alu_cls_e         i_cls,
  input  logic [5:0]       i_opcode,
  input  logic [5:0]       i_funct,
  output logic [ALU_W-1:0] o_alu_ctrl,
  output logic [1:0]       o_ext_mode
);

  logic [3:0] w_alu;
  logic [1:0] w_ext;

  always_comb begin
    w_alu = ALU_AND;
    w_ext = EXT_SIGN;
    unique case (1'b1)
      (i_cls == C_ADD): w_alu = ALU_ADD;
      (i_cls == C_SUB): w_alu = ALU_SUB;
      (i_cls == C_R): begin
        case (i_funct)
          FN_SUB:  w_alu = ALU_SUB;
          FN_AND:  w_alu = ALU_AND;
          FN_OR:   w_alu = ALU_OR;
          FN_SLT:  w_alu = ALU_SLT;
          default: w_alu = ALU_ADD;
        endcase
      end
      (i_cls == C_I): begin
        case (i_opcode)
          OP_SLTI: w_alu = ALU_SLT;
          OP_ANDI: begin
            w_alu = ALU_AND;
            w_ext = EXT_ZERO;
          end
          OP_ORI: begin
            w_alu = ALU_OR;
            w_ext = EXT_ZERO;
          end
          OP_LUI: begin
            w_alu = ALU_ADD;
            w_ext = EXT_UPPER;
          end
          default: w_alu = ALU_ADD;
        endcase
      end
      default: begin
        w_alu = ALU_AND;
        w_ext = EXT_SIGN;
      end
    endcase
  end

  assign o_alu_ctrl = ALU_W'(w_alu);
  assign o_ext_mode = w_ext;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: registered state,
// outputs decoded from state (plus IR fields, zero, mem_ready).
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int ALU_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_en,
  output logic [1:0]         pc_src,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         ext_mode,
  output logic [ALU_W-1:0]   alu_ctrl,
  output logic               illegal,
  output logic [STATE_W-1:0] dbg_state
);

  state_e   r_state;
  state_e   w_next;
  logic     r_illegal;
  alu_cls_e w_cls;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:    w_next = S_MEMADR;
          OP_R:            w_next = S_REX;
          OP_ADDI, OP_SLTI, OP_ANDI,
          OP_ORI, OP_LUI:  w_next = S_IEX;
          OP_BEQ, OP_BNE:  w_next = S_BRANCH;
          OP_J:            w_next = S_JUMP;
          default:         w_next = S_TRAP;
        endcase
      end
      S_MEMADR:
        w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWR:  if (mem_ready) w_next = S_FETCH;
      S_REX:
        w_next = funct_ok(funct) ? S_ALUWB : S_TRAP;
      S_IEX:    w_next = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP:
        w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = PCSRC_ALU;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    w_cls      = C_NONE;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_4;
        w_cls     = C_ADD;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM2;
        w_cls     = C_ADD;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_cls     = C_ADD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_REX: begin
        alu_src_a = 1'b1;
        w_cls     = C_R;
      end
      S_IEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_cls     = C_I;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == OP_R);
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        w_cls     = C_SUB;
        pc_src    = PCSRC_OUT;
        pc_en     = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        pc_src = PCSRC_JMP;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

  mips_multicycle_ctrl_alu_dec #(
    .ALU_W(ALU_W)
  ) u_alu_dec (
    .i_cls      (w_cls),
    .i_opcode   (opcode),
    .i_funct    (funct),
    .o_alu_ctrl (alu_ctrl),
    .o_ext_mode (ext_mode)
  );

  assign illegal   = r_illegal;
  assign dbg_state = STATE_W'(r_state);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench: instruction-level step queue model plus
// a per-cycle compare process and a few literal pins.
module tb_mips_multicycle_ctrl;

  typedef enum logic [3:0] {
    T_IDLE, T_FETCH, T_DECODE, T_MEMADR, T_MEMRD,
    T_MEMWB, T_MEMWR, T_REX, T_ALUWB, T_IEX,
    T_BRANCH, T_JUMP, T_TRAP
  } st_e;

  typedef struct {
    st_e        st;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h0;
  logic [5:0] funct = 6'h0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, iord, ir_write;
  logic       pc_en, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, illegal;
  logic [1:0] pc_src, alu_src_b, ext_mode;
  logic [3:0] alu_ctrl, dbg_state;

  int total = 0;
  int bad = 0;
  ent_t q[$];
  logic [5:0] cur_op, cur_fn;
  logic       cur_z;
  logic       sticky = 1'b0;

  mips_multicycle_ctrl #(.STATE_W(4), .ALU_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .pc_en(pc_en),
    .pc_src(pc_src), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_mode(ext_mode), .alu_ctrl(alu_ctrl),
    .illegal(illegal), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm,
                     input logic [7:0] got,
                     input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, got, want, $time);
    end
  endtask

  // Expected behaviour of one micro-step, from the rules.
  logic [1:0] x_b, x_ext, x_pcs;
  logic [3:0] x_alu;
  logic x_mr, x_mw, x_ir, x_pce, x_rw, x_io, x_a;
  logic x_dst, x_m2r;
  logic c_sel, c_alu, c_pcs, c_io, c_wb;
  ent_t e;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.st == T_IDLE) sticky = 1'b0;
      if (e.st == T_TRAP) sticky = 1'b1;
      {x_mr, x_mw, x_ir, x_pce, x_rw} = '0;
      {x_io, x_a, x_dst, x_m2r} = '0;
      x_b = 2'b00; x_ext = 2'b00;
      x_pcs = 2'b00; x_alu = 4'b0000;
      {c_sel, c_alu, c_pcs, c_io, c_wb} = '0;
      case (e.st)
        T_IDLE: {c_sel, c_alu, c_pcs, c_io, c_wb} = '1;
        T_FETCH: begin
          x_mr = 1; x_b = 2'b01; x_alu = 4'b0010;
          x_ir = e.rdy; x_pce = e.rdy;
          c_sel = 1; c_alu = 1; c_io = 1; c_pcs = e.rdy;
        end
        T_DECODE: begin
          x_b = 2'b11; x_alu = 4'b0010;
          c_sel = 1; c_alu = 1;
        end
        T_MEMADR: begin
          x_a = 1; x_b = 2'b10; x_alu = 4'b0010;
          c_sel = 1; c_alu = 1;
        end
        T_MEMRD: begin x_mr = 1; x_io = 1; c_io = 1; end
        T_MEMWR: begin x_mw = 1; x_io = 1; c_io = 1; end
        T_MEMWB: begin
          x_rw = 1; x_m2r = 1; c_wb = 1;
        end
        T_REX: begin
          x_a = 1; x_b = 2'b00; c_sel = 1;
          c_alu = 1;
          case (e.fn)
            6'h20: x_alu = 4'b0010;
            6'h22: x_alu = 4'b0110;
            6'h24: x_alu = 4'b0000;
            6'h25: x_alu = 4'b0001;
            6'h2a: x_alu = 4'b0111;
            default: c_alu = 0;
          endcase
        end
        T_IEX: begin
          x_a = 1; x_b = 2'b10; c_sel = 1; c_alu = 1;
          case (e.op)
            6'h0a: x_alu = 4'b0111;
            6'h0c: begin x_alu = 4'b0000; x_ext = 2'b01; end
            6'h0d: begin x_alu = 4'b0001; x_ext = 2'b01; end
            6'h0f: begin x_alu = 4'b0010; x_ext = 2'b10; end
            default: x_alu = 4'b0010;
          endcase
        end
        T_ALUWB: begin
          x_rw = 1; x_dst = (e.op == 6'h00); c_wb = 1;
        end
        T_BRANCH: begin
          x_a = 1; x_b = 2'b00; x_alu = 4'b0110;
          x_pcs = 2'b01; c_sel = 1; c_alu = 1; c_pcs = 1;
          x_pce = (e.op == 6'h04) ? e.z : !e.z;
        end
        T_JUMP: begin
          x_pcs = 2'b10; x_pce = 1; c_pcs = 1;
        end
        default: ;
      endcase
      chk("state", 8'(dbg_state), 8'(e.st));
      chk("mem_read", 8'(mem_read), 8'(x_mr));
      chk("mem_write", 8'(mem_write), 8'(x_mw));
      chk("ir_write", 8'(ir_write), 8'(x_ir));
      chk("pc_en", 8'(pc_en), 8'(x_pce));
      chk("reg_write", 8'(reg_write), 8'(x_rw));
      chk("illegal", 8'(illegal), 8'(sticky));
      if (c_sel) begin
        chk("alu_src_a", 8'(alu_src_a), 8'(x_a));
        chk("alu_src_b", 8'(alu_src_b), 8'(x_b));
      end
      if (c_alu) begin
        chk("alu_ctrl", 8'(alu_ctrl), 8'(x_alu));
        chk("ext_mode", 8'(ext_mode), 8'(x_ext));
      end
      if (c_pcs) chk("pc_src", 8'(pc_src), 8'(x_pcs));
      if (c_io) chk("iord", 8'(iord), 8'(x_io));
      if (c_wb) begin
        chk("reg_dst", 8'(reg_dst), 8'(x_dst));
        chk("mem_to_reg", 8'(mem_to_reg), 8'(x_m2r));
      end
    end
  end

  task automatic push(input st_e s, input logic rdy);
    ent_t n;
    n.st = s; n.op = cur_op; n.fn = cur_fn;
    n.z = cur_z; n.rdy = rdy;
    q.push_back(n);
  endtask

  task automatic step(input st_e s, input logic rdy);
    @(posedge clk); #1;
    opcode = cur_op; funct = cur_fn;
    zero = cur_z; mem_ready = rdy;
    push(s, rdy);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mem_read", 8'(mem_read), 8'h0);
    chk("rst_mem_write", 8'(mem_write), 8'h0);
    chk("rst_reg_write", 8'(reg_write), 8'h0);
    chk("rst_pc_en", 8'(pc_en), 8'h0);
    chk("rst_ir_write", 8'(ir_write), 8'h0);
    chk("rst_state", 8'(dbg_state), 8'h0);
    chk("rst_illegal", 8'(illegal), 8'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(T_IDLE, 1'b0);
    #1;
  endtask

  task automatic fetch_dec(input logic [5:0] op,
                           input logic [5:0] fn,
                           input logic z, input int fw);
    cur_op = op; cur_fn = fn; cur_z = z;
    for (int i = 0; i < fw; i++) step(T_FETCH, 1'b0);
    step(T_FETCH, 1'b1);
    step(T_DECODE, 1'($urandom_range(0, 1)));
  endtask

  task automatic instr(input logic [5:0] op,
                       input logic [5:0] fn,
                       input logic z,
                       input int fw, input int mw);
    fetch_dec(op, fn, z, fw);
    case (op)
      6'h23: begin
        step(T_MEMADR, 1'b1);
        for (int i = 0; i < mw; i++) step(T_MEMRD, 1'b0);
        step(T_MEMRD, 1'b1);
        step(T_MEMWB, 1'b1);
      end
      6'h2b: begin
        step(T_MEMADR, 1'b1);
        for (int i = 0; i < mw; i++) step(T_MEMWR, 1'b0);
        step(T_MEMWR, 1'b1);
      end
      6'h00: begin
        step(T_REX, 1'b1);
        step(T_ALUWB, 1'b1);
      end
      6'h04, 6'h05: step(T_BRANCH, 1'b1);
      6'h02: step(T_JUMP, 1'b1);
      default: begin
        step(T_IEX, 1'b1);
        step(T_ALUWB, 1'b1);
      end
    endcase
  endtask

  logic [5:0] rfn [4] = '{6'h22, 6'h24, 6'h25, 6'h2a};
  logic [5:0] iop [3] = '{6'h0a, 6'h0c, 6'h08};

  initial begin
    #3;
    chk("init_state", 8'(dbg_state), 8'h0);
    do_reset();

    instr(6'h00, 6'h20, 1'b0, 0, 0);
    chk("add_wb_rw", 8'(reg_write), 8'h1);
    chk("add_wb_dst", 8'(reg_dst), 8'h1);
    for (int i = 0; i < 4; i++)
      instr(6'h00, rfn[i], 1'b0, i % 2, 0);

    fetch_dec(6'h23, 6'h00, 1'b0, 0);
    step(T_MEMADR, 1'b1);
    step(T_MEMRD, 1'b0);
    chk("lw_wait_rd", 8'(mem_read), 8'h1);
    chk("lw_wait_iord", 8'(iord), 8'h1);
    step(T_MEMRD, 1'b0);
    step(T_MEMRD, 1'b1);
    step(T_MEMWB, 1'b1);
    chk("lw_wb_m2r", 8'(mem_to_reg), 8'h1);
    chk("lw_wb_state", 8'(dbg_state), 8'h5);

    instr(6'h2b, 6'h00, 1'b0, 1, 1);
    instr(6'h04, 6'h00, 1'b1, 0, 0);
    chk("beq_t_pcen", 8'(pc_en), 8'h1);
    chk("beq_t_pcsrc", 8'(pc_src), 8'h1);
    instr(6'h04, 6'h00, 1'b0, 0, 0);
    chk("beq_n_pcen", 8'(pc_en), 8'h0);
    instr(6'h05, 6'h00, 1'b1, 0, 0);
    chk("bne_z_pcen", 8'(pc_en), 8'h0);
    instr(6'h05, 6'h00, 1'b0, 0, 0);

    fetch_dec(6'h0d, 6'h00, 1'b0, 0);
    step(T_IEX, 1'b1);
    chk("ori_ext", 8'(ext_mode), 8'h1);
    chk("ori_alu", 8'(alu_ctrl), 8'h1);
    step(T_ALUWB, 1'b1);
    fetch_dec(6'h0f, 6'h00, 1'b0, 0);
    step(T_IEX, 1'b1);
    chk("lui_ext", 8'(ext_mode), 8'h2);
    step(T_ALUWB, 1'b1);
    chk("lui_wb_dst", 8'(reg_dst), 8'h0);
    fetch_dec(6'h08, 6'h00, 1'b0, 0);
    step(T_IEX, 1'b1);
    chk("addi_ext", 8'(ext_mode), 8'h0);
    chk("addi_alu", 8'(alu_ctrl), 8'h2);
    step(T_ALUWB, 1'b1);
    for (int i = 0; i < 3; i++)
      instr(iop[i], 6'h00, 1'b0, 0, 0);
    instr(6'h02, 6'h00, 1'b0, 0, 0);
    chk("j_pcsrc", 8'(pc_src), 8'h2);

    fetch_dec(6'h2b, 6'h00, 1'b0, 0);
    step(T_MEMADR, 1'b1);
    step(T_MEMWR, 1'b0);
    step(T_MEMWR, 1'b0);
    chk("sw_mid_wr", 8'(mem_write), 8'h1);
    do_reset();
    instr(6'h00, 6'h20, 1'b0, 0, 0);

    fetch_dec(6'h3f, 6'h00, 1'b0, 0);
    for (int i = 0; i < 3; i++)
      step(T_TRAP, 1'($urandom_range(0, 1)));
    chk("trap_illegal", 8'(illegal), 8'h1);
    do_reset();

    fetch_dec(6'h00, 6'h07, 1'b0, 0);
    step(T_REX, 1'b1);
    step(T_TRAP, 1'b1);
    step(T_TRAP, 1'b0);
    chk("rtrap_illegal", 8'(illegal), 8'h1);
    do_reset();
    instr(6'h23, 6'h00, 1'b0, 0, 0);

    @(posedge clk); #6;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
